mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single data port of the memory controller between two requesters: the pipeline MEM stage (read/write) and the display frame reader (read-only, RAM image region). It sits between those requesters and the memory controller's `we`/`address`/`wd`/`rd` port. CPU accesses have fixed priority, with a bounded-wait override so the display is never starved. Reads are pipelined one per cycle, with one cycle of memory read latency.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: number of consecutive denied display cycles before the display gets priority (1..15).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; held until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU byte address (memory-controller map).
- `cpu_wd` in DATA_W: CPU write data.
- `cpu_rd` out DATA_W: CPU read data; valid while `cpu_ready` is high on a read.
- `cpu_ready` out 1: CPU access complete; pipeline stall = `cpu_req & ~cpu_ready`.
- `vga_req` in 1: display read request.
- `vga_addr` in ADDR_W: display address, must lie in [8500, 138100).
- `vga_gnt` out 1: display request accepted this cycle; the reader may advance its address.
- `vga_rd` out DATA_W: display read data.
- `vga_valid` out 1: `vga_rd` valid.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wd` out DATA_W: to the memory controller.
- `mem_rd` in DATA_W: from the memory controller; valid one cycle after the address.

## Operation
- The return-owner register `ret_own` is the only state, with values NONE, CPU and VGA. It records who owns the read data arriving this cycle.
- Grant is combinational each cycle; at most one of `gnt_cpu` and `vga_gnt` is high:
  - `cpu_eligible = cpu_req & ~(ret_own==CPU)`. A CPU read whose data returns this cycle is complete and is not re-granted.
  - `vga_prio = (wait_cnt == MAX_WAIT)`.
  - If `vga_prio & vga_req`, grant VGA. Otherwise, if `cpu_eligible`, grant CPU. Otherwise, if `vga_req`, grant VGA.
- Memory port:
  - On a CPU grant, `mem_*` = CPU signals.
  - On a VGA grant, `mem_addr` = `vga_addr`, `mem_we` = 0, `mem_wd` = 0.
  - With no grant, `mem_*` = 0.
- `ret_own` next value: CPU if CPU is granted with `cpu_we`=0; VGA if VGA is granted; otherwise NONE.
- CPU completion:
  - A write completes in its grant cycle, with `cpu_ready`=1.
  - A read completes when `ret_own==CPU`: `cpu_ready`=1 and `cpu_rd` = `mem_rd`.
  - `cpu_rd` = 0 otherwise.
- Display completion: when `ret_own==VGA`, `vga_valid`=1 and `vga_rd` = `mem_rd`; otherwise `vga_rd` = 0.
- Wait counter `wait_cnt`, 4 bits:
  - Cleared on a VGA grant or when `vga_req`=0.
  - Incremented when `vga_req & ~vga_gnt`.
  - Saturates at `MAX_WAIT`.
- A CPU write and a display read never overlap, because only one grant is issued per cycle.

## Timing
- Reset (`reset_n`=0, asynchronous): `ret_own`=NONE and `wait_cnt`=0. All outputs are 0: `cpu_ready`, `cpu_rd`, `vga_gnt`, `vga_rd`, `vga_valid`, `mem_we`, `mem_addr`, `mem_wd`.
- Reset asserted mid-read: the in-flight return is discarded, and no ready/valid pulse is issued after release.
- Latency:
  - CPU write: 0 extra cycles (`cpu_ready` in the request cycle when granted).
  - CPU read: 1 cycle (grant at t, data and `cpu_ready` at t+1).
  - VGA: `vga_gnt` at t, `vga_valid` at t+1.
- Throughput is one access per cycle. Back-to-back VGA reads return data every cycle.
- A CPU read issued at t cannot be re-granted at t+1. VGA may use the port at t+1.
- Worst-case VGA wait is `MAX_WAIT` cycles. Worst-case CPU wait is 1 cycle per `MAX_WAIT` VGA-denied cycles.
- `reset_n` is assumed synchronously deasserted by the top-level reset synchroniser.

## Structure
- Package `mem_arb_pkg` holds:
  - `owner_t` enum (`OWN_NONE`, `OWN_CPU`, `OWN_VGA`).
  - Region constants `RAM_BASE`=8500, `RAM_END`=138100, `ROM_BASE`=400, `SENO_BASE`=138100.
- One sub-module, `arb_starve_counter`: the saturating wait counter, with inputs `req`/`gnt` and output `at_limit`, parameterised by `MAX_WAIT`.
- The top level holds the grant logic, `ret_own`, and the muxes.

## Test plan
- CPU read of 8500 only: the cycle-t `mem_addr` is 8500, `mem_we`=0. At t+1, `cpu_ready`=1 and `cpu_rd` = `mem_rd` (model returns 0xDEADBEEF). `vga_valid` stays 0.
- CPU write to 8504 with 0x12345678: same cycle `mem_we`=1, `mem_addr`=8504, `mem_wd`=0x12345678, `cpu_ready`=1. A following read of 8504 returns 0x12345678.
- `vga_req` held with consecutive addresses 8500, 8504, …: `vga_gnt` every cycle, `vga_valid` every cycle from t+1, data matching addresses in order.
- Both requesting continuously, `MAX_WAIT`=4:
  - CPU is granted for 4 cycles, then VGA is granted on the 5th and `wait_cnt` clears.
  - The pattern repeats.
  - `cpu_ready` never asserts in a cycle where VGA is granted with a CPU write pending.
- CPU read at t with `cpu_req` still high at t+1 and `vga_req` high: `cpu_ready`=1 at t+1 and VGA is granted at t+1, not the CPU.
- `reset_n` pulsed low at t+1 after a VGA grant at t: `vga_valid` stays 0, all outputs are 0 during reset, and `wait_cnt` is 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and memory-map constants for the memory port arbiter.
//   owner_t  : who owns the read data returning from the memory controller
//   RAM_*    : display-readable RAM image region [RAM_BASE, RAM_END)
//   ROM_BASE, SENO_BASE : neighbouring regions of the controller's map
//   in_ram() : true when an address lies inside the RAM image region
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam logic [31:0] ROM_BASE  = 32'd400;
    localparam logic [31:0] RAM_BASE  = 32'd8500;
    localparam logic [31:0] RAM_END   = 32'd138100;
    localparam logic [31:0] SENO_BASE = 32'd138100;

    function automatic logic in_ram(input logic [31:0] addr);
        return (addr >= RAM_BASE) && (addr < RAM_END);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
// Counts consecutive cycles in which a request is pending but not granted,
// saturating at MAX_WAIT. at_limit tells the arbiter to give this requester
// priority on the next opportunity.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : requester is asking this cycle
//   gnt          : requester was granted this cycle
//   at_limit     : counter has reached MAX_WAIT
module arb_starve_counter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic gnt,
    output logic at_limit
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != 4'(MAX_WAIT)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_limit = (cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the memory controller's single data port between the CPU MEM stage
// (read/write, fixed priority) and the display frame reader (read-only).
// After MAX_WAIT consecutive denied cycles the display takes priority.
// Reads have one cycle of latency; ret_own tags the returning data.
//   CPU side     : cpu_req/cpu_we/cpu_addr/cpu_wd in, cpu_rd/cpu_ready out
//   Display side : vga_req/vga_addr in, vga_gnt/vga_rd/vga_valid out
//   Memory side  : mem_we/mem_addr/mem_wd out, mem_rd in
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_ready,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rd,
    output logic              vga_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    owner_t ret_own;
    logic   vga_prio;
    logic   cpu_eligible;
    logic   gnt_cpu;
    logic   gnt_vga;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (vga_req),
        .gnt      (gnt_vga),
        .at_limit (vga_prio)
    );

    // Grants are gated by reset_n so every output is 0 while reset is held,
    // even though the grant path is combinational from the requests.
    always_comb begin
        gnt_cpu      = 1'b0;
        gnt_vga      = 1'b0;
        // A CPU read whose data is returning now is finished; do not reissue it.
        cpu_eligible = cpu_req && (ret_own != OWN_CPU);
        if (reset_n) begin
            if (vga_prio && vga_req) begin
                gnt_vga = 1'b1;
            end else if (cpu_eligible) begin
                gnt_cpu = 1'b1;
            end else if (vga_req) begin
                gnt_vga = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (gnt_cpu) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end else if (gnt_vga) begin
            mem_addr = vga_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_own <= OWN_NONE;
        end else if (gnt_cpu && !cpu_we) begin
            ret_own <= OWN_CPU;
        end else if (gnt_vga) begin
            ret_own <= OWN_VGA;
        end else begin
            ret_own <= OWN_NONE;
        end
    end

    always_comb begin
        vga_gnt   = gnt_vga;
        cpu_ready = (gnt_cpu && cpu_we) || (ret_own == OWN_CPU);
        cpu_rd    = (ret_own == OWN_CPU) ? mem_rd : '0;
        vga_valid = (ret_own == OWN_VGA);
        vga_rd    = (ret_own == OWN_VGA) ? mem_rd : '0;
    end

    a_vga_in_ram: assert property (@(posedge clk) disable iff (!reset_n)
        vga_req |-> in_ram(32'(vga_addr)));

endmodule
